// File: rtl/position_sequencer.sv
// position_sequencer: moves a three-position actuator one step at a time
// (home <-> mid <-> front), dwelling STEP_CYCLES clocks at each position.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for a request, req_ready high
//   S_DWELL | counting down at the current position before the next step
//   S_DONE  | target reached, arrive pulses for this single cycle
module position_sequencer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_target,
  output logic       req_ready,
  input  logic       hold,
  output logic [1:0] pos,
  output logic       busy,
  output logic       arrive,
  output logic       err
);

  // A single-cycle dwell still needs a 1-bit counter that just stays at 0.
  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] POS_HOME    = 2'b00;
  localparam logic [1:0] POS_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_DWELL = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       pos_q, pos_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             accept;
  logic [1:0]       pos_step;

  // Handshake and single-step move toward the latched target. In DWELL the
  // target always differs from pos, and pos is only ever 00/01/10, so a +/-1
  // step can never skip mid or reach 11.
  always_comb begin
    accept   = req_valid && (state_q == S_IDLE);
    pos_step = (tgt_q > pos_q) ? (pos_q + 2'd1) : (pos_q - 2'd1);
  end

  // Next-state, position, target and dwell counter.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_target == POS_ILLEGAL) begin
            err_d = 1'b1;
          end else if (req_target == pos_q) begin
            state_d = S_DONE;
          end else begin
            tgt_d   = req_target;
            cnt_d   = RELOAD;
            state_d = S_DWELL;
          end
        end
      end

      S_DWELL: begin
        if (!hold) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            pos_d = pos_step;
            if (pos_step == tgt_q) begin
              state_d = S_DONE;
            end else begin
              cnt_d = RELOAD;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset wins over any accept, hold or step in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pos_q   <= POS_HOME;
      tgt_q   <= POS_HOME;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    arrive    = (state_q == S_DONE);
    err       = err_q;
    pos       = pos_q;
  end

endmodule

// File: tb/tb_position_sequencer.sv
// Bench for position_sequencer (STEP_CYCLES = 4). Expected observations are
// queued with the edge number they belong to when stimulus is driven, and
// a negedge monitor pops and compares them as that edge passes.
module tb_position_sequencer;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_target;
  logic       req_ready;
  logic       hold;
  logic [1:0] pos;
  logic       busy;
  logic       arrive;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  localparam int SEL_POS   = 0;
  localparam int SEL_BUSY  = 1;
  localparam int SEL_READY = 2;
  localparam int SEL_ARR   = 3;
  localparam int SEL_ERR   = 4;

  typedef struct {
    int         cyc;
    string      tag;
    int         sel;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];

  position_sequencer #(.STEP_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_ready  (req_ready),
    .hold       (hold),
    .pos        (pos),
    .busy       (busy),
    .arrive     (arrive),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h want %0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] observe(input int sel);
    case (sel)
      SEL_POS:   return {2'b00, pos};
      SEL_BUSY:  return {3'b000, busy};
      SEL_READY: return {3'b000, req_ready};
      SEL_ARR:   return {3'b000, arrive};
      default:   return {3'b000, err};
    endcase
  endfunction

  // Queue an expectation for the value seen after edge c, kept sorted by edge.
  task automatic expect_at(input int c, input string tag, input int sel, input int v);
    exp_t e;
    int   i;
    e.cyc = c;
    e.tag = tag;
    e.sel = sel;
    e.val = 4'(v);
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  // Monitor: compare everything due at the current edge, mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) chk({e.tag, "_missed"}, 4'd1, 4'd0);
      else             chk(e.tag, observe(e.sel), e.val);
    end
  end

  task automatic wait_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request now (just after an edge); it is accepted on the next edge.
  task automatic issue(input logic [1:0] t, output int e0);
    req_valid  = 1'b1;
    req_target = t;
    e0 = cyc + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int e1;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_target = 2'b00;
    hold       = 1'b0;

    // Reset held for two edges.
    expect_at(2, "rst_pos",   SEL_POS,   0);
    expect_at(2, "rst_busy",  SEL_BUSY,  0);
    expect_at(2, "rst_ready", SEL_READY, 1);
    expect_at(2, "rst_arr",   SEL_ARR,   0);
    expect_at(2, "rst_err",   SEL_ERR,   0);
    wait_cycle(2);
    rst = 1'b0;

    // Zero-distance request at home.
    issue(2'b00, e0);
    expect_at(e0,   "zd_busy",   SEL_BUSY,  1);
    expect_at(e0,   "zd_arr",    SEL_ARR,   1);
    expect_at(e0,   "zd_pos",    SEL_POS,   0);
    expect_at(e0,   "zd_ready",  SEL_READY, 0);
    expect_at(e0+1, "zd_busy2",  SEL_BUSY,  0);
    expect_at(e0+1, "zd_arr2",   SEL_ARR,   0);
    expect_at(e0+1, "zd_ready2", SEL_READY, 1);
    expect_at(e0+1, "zd_pos2",   SEL_POS,   0);
    wait_cycle(e0);
    req_valid = 1'b0;
    wait_cycle(e0+1);

    // Home to front, with a request presented mid-move that must be ignored.
    issue(2'b10, e0);
    expect_at(e0,   "hf_busy",   SEL_BUSY,  1);
    expect_at(e0+3, "hf_pos3",   SEL_POS,   0);
    expect_at(e0+4, "hf_pos4",   SEL_POS,   1);
    expect_at(e0+7, "hf_pos7",   SEL_POS,   1);
    expect_at(e0+7, "hf_arr7",   SEL_ARR,   0);
    expect_at(e0+8, "hf_pos8",   SEL_POS,   2);
    expect_at(e0+8, "hf_arr8",   SEL_ARR,   1);
    expect_at(e0+8, "hf_ready8", SEL_READY, 0);
    expect_at(e0+9, "hf_arr9",   SEL_ARR,   0);
    expect_at(e0+9, "hf_ready9", SEL_READY, 1);
    expect_at(e0+9, "hf_busy9",  SEL_BUSY,  0);
    expect_at(e0+9, "hf_pos9",   SEL_POS,   2);
    wait_cycle(e0);
    req_valid = 1'b0;
    wait_cycle(e0+2);
    req_valid  = 1'b1;
    req_target = 2'b00;
    wait_cycle(e0+3);
    req_valid = 1'b0;
    wait_cycle(e0+9);

    // Illegal target at front, followed immediately by a legal request to mid.
    issue(2'b11, e0);
    e1 = e0 + 1;
    expect_at(e0,   "il_err",    SEL_ERR,   1);
    expect_at(e0,   "il_ready",  SEL_READY, 1);
    expect_at(e0,   "il_busy",   SEL_BUSY,  0);
    expect_at(e0,   "il_pos",    SEL_POS,   2);
    expect_at(e1,   "il_err2",   SEL_ERR,   0);
    expect_at(e1,   "il_busy2",  SEL_BUSY,  1);
    expect_at(e1+3, "fm_pos3",   SEL_POS,   2);
    expect_at(e1+4, "fm_pos4",   SEL_POS,   1);
    expect_at(e1+4, "fm_arr4",   SEL_ARR,   1);
    expect_at(e1+5, "fm_ready5", SEL_READY, 1);
    wait_cycle(e0);
    req_target = 2'b01;
    wait_cycle(e1);
    req_valid = 1'b0;
    wait_cycle(e1+5);

    // Mid back to home.
    issue(2'b00, e0);
    expect_at(e0+4, "mh_pos4", SEL_POS, 0);
    expect_at(e0+4, "mh_arr4", SEL_ARR, 1);
    wait_cycle(e0);
    req_valid = 1'b0;
    wait_cycle(e0+5);

    // Home to mid with hold high for three edges of the first dwell.
    issue(2'b01, e0);
    expect_at(e0+4, "hd_pos4", SEL_POS, 0);
    expect_at(e0+6, "hd_pos6", SEL_POS, 0);
    expect_at(e0+6, "hd_arr6", SEL_ARR, 0);
    expect_at(e0+7, "hd_pos7", SEL_POS, 1);
    expect_at(e0+7, "hd_arr7", SEL_ARR, 1);
    wait_cycle(e0);
    req_valid = 1'b0;
    hold      = 1'b1;
    wait_cycle(e0+3);
    hold = 1'b0;
    wait_cycle(e0+8);

    // Back home, then reset at edge 5 of a home-to-front move.
    issue(2'b00, e0);
    expect_at(e0+4, "rh_pos4", SEL_POS, 0);
    wait_cycle(e0);
    req_valid = 1'b0;
    wait_cycle(e0+5);

    issue(2'b10, e0);
    expect_at(e0+4, "rm_pos4",   SEL_POS,   1);
    expect_at(e0+5, "rm_pos5",   SEL_POS,   0);
    expect_at(e0+5, "rm_busy5",  SEL_BUSY,  0);
    expect_at(e0+5, "rm_ready5", SEL_READY, 1);
    expect_at(e0+5, "rm_arr5",   SEL_ARR,   0);
    expect_at(e0+8, "rm_arr8",   SEL_ARR,   0);
    expect_at(e0+9, "rm_arr9",   SEL_ARR,   0);
    expect_at(e0+9, "rm_pos9",   SEL_POS,   0);
    wait_cycle(e0);
    req_valid = 1'b0;
    wait_cycle(e0+4);
    rst = 1'b1;
    wait_cycle(e0+5);
    rst = 1'b0;
    wait_cycle(e0+10);

    // Request after the aborted move is accepted normally.
    issue(2'b01, e0);
    expect_at(e0,   "ra_busy",   SEL_BUSY,  1);
    expect_at(e0+4, "ra_pos4",   SEL_POS,   1);
    expect_at(e0+4, "ra_arr4",   SEL_ARR,   1);
    expect_at(e0+5, "ra_ready5", SEL_READY, 1);
    wait_cycle(e0);
    req_valid = 1'b0;
    wait_cycle(e0+5);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    #1;
    if (sb.size() > 0) chk("sb_drain", 4'd1, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/position_sequencer.md
POSITION_SEQUENCER -- requirements
Module: position_sequencer

Interface
REQ-001 Parameter STEP_CYCLES, default 4, range >=1: clock cycles spent at each position before stepping to the adjacent one.
REQ-002 Port clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port req_valid  input  1  move request present.
REQ-005 Port req_target  input  2  requested position: 2'b00 home, 2'b01 mid, 2'b10 front, 2'b11 illegal.
REQ-006 Port req_ready  output  1  block can accept a request this cycle.
REQ-007 Port hold  input  1  freezes the dwell counter while high.
REQ-008 Port pos  output  2  current position code, same encoding as req_target, registered.
REQ-009 Port busy  output  1  high whenever state is not IDLE.
REQ-010 Port arrive  output  1  one-cycle pulse: target reached.
REQ-011 Port err  output  1  one-cycle pulse: illegal target rejected.

Function
REQ-012 The FSM SHALL have three states: IDLE, DWELL and DONE.
REQ-013 req_ready SHALL be 1 in IDLE and 0 in DWELL and DONE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-014 An accept with req_target == 2'b11 SHALL leave state IDLE and pos unchanged, and SHALL drive err = 1 for exactly the following cycle.
REQ-015 An accept with req_target == pos SHALL go to DONE without changing pos.
REQ-016 Any other accept SHALL latch the target, load the dwell counter with STEP_CYCLES-1 and go to DWELL.
REQ-017 In DWELL with hold = 0 and counter > 0, the counter SHALL decrement by 1 per cycle.
REQ-018 In DWELL with hold = 1, the counter and pos SHALL hold, and hold SHALL have no effect in IDLE or DONE.
REQ-019 In DWELL with hold = 0 and counter == 0, pos SHALL step one position toward the target (00<->01<->10, never skipping mid).
  - if the new pos equals the target: go to DONE.
  - otherwise: reload the counter with STEP_CYCLES-1 and stay in DWELL.
REQ-020 arrive SHALL equal (state == DONE), and DONE SHALL return to IDLE on the next edge unconditionally.
REQ-021 Timing with accept on edge E0 and no hold: first pos change after edge E0+STEP_CYCLES, second (home<->front) after edge E0+2*STEP_CYCLES, req_ready high again one cycle after arrive.
REQ-022 STEP_CYCLES = 1 SHALL step pos on every edge in DWELL.
REQ-023 The counter width SHALL be max(1, clog2(STEP_CYCLES)) bits and SHALL never wrap below 0.
REQ-024 pos SHALL never take the value 2'b11.
REQ-025 req_valid and req_target SHALL be ignored while req_ready = 0; no request is queued.

Reset
REQ-026 rst = 1 SHALL on the next edge force state IDLE, pos = 2'b00, counter = 0, latched target = 2'b00, and arrive = err = busy = 0, with req_ready = 1.
REQ-027 Reset SHALL take priority over any accept, hold or step in the same cycle, including mid-move; the in-flight move is discarded and no arrive is produced.

Verification (STEP_CYCLES = 4)
REQ-028 Reset: assert rst for 2 cycles -> pos = 00, busy = 0, req_ready = 1, arrive = 0, err = 0.
REQ-029 Home to front: target 10 accepted at edge 0 -> pos = 01 after edge 4, pos = 10 after edge 8, arrive high only in the cycle after edge 8, req_ready = 1 after edge 9.
REQ-030 Zero-distance: at pos 00, target 00 accepted -> arrive and busy high for exactly one cycle, pos stays 00.
REQ-031 Illegal target 11 accepted -> err high for one cycle, pos unchanged, req_ready stays 1, and a valid request on the next cycle is accepted.
REQ-032 hold = 1 for 3 cycles during the first dwell of home to mid -> pos = 01 after edge 7 instead of edge 4.
REQ-033 rst asserted at edge 5 of a home-to-front move -> pos = 00, IDLE, no arrive pulse, and the next request is accepted normally.
